// File: rtl/mult_seq_pkg.sv
// Shared types and default widths for the multiplier host sequencer.
package mult_seq_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int RES_W_DEF  = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_WAIT  = 3'd2,
    ST_RESP  = 3'd3,
    ST_FAULT = 3'd4
  } state_e;

endpackage

// File: rtl/mult_seq_watchdog.sv
// Start-to-done cycle counter for the sequencer; expired flags the TIMEOUT-th
// enabled cycle so a done arriving in that same cycle can still win.
module mult_seq_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != CW'(TIMEOUT))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = enable && (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mult_host_seq.sv
// Host sequencer: one operand pair in flight to the multiplier, result out on
// a valid/ready stream. Optional watchdog under MULT_SEQ_WATCHDOG_EN.
module mult_host_seq
  import mult_seq_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int RES_W   = RES_W_DEF,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic              mul_start,
  output logic [DATA_W-1:0] mul_a,
  output logic [DATA_W-1:0] mul_b,
  input  logic              mul_done,
  input  logic [RES_W-1:0]  mul_res,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [RES_W-1:0]  out_res,
  output logic              busy,
  output logic              err
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] mul_a_q, mul_a_d;
  logic [DATA_W-1:0] mul_b_q, mul_b_d;
  logic [RES_W-1:0]  out_res_q, out_res_d;
  logic              wd_expired;

`ifdef MULT_SEQ_WATCHDOG_EN
  mult_seq_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (state_q == ST_START),
    .enable (state_q == ST_WAIT),
    .expired(wd_expired)
  );
  assign err = (state_q == ST_FAULT);
`else
  assign wd_expired = 1'b0;
  assign err        = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    mul_a_d   = mul_a_q;
    mul_b_d   = mul_b_q;
    out_res_d = out_res_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          mul_a_d = in_a;
          mul_b_d = in_b;
          state_d = ST_START;
        end
      end
      ST_START: state_d = ST_WAIT;
      ST_WAIT: begin
        // done takes priority over a watchdog expiry in the same cycle
        if (mul_done) begin
          out_res_d = mul_res;
          state_d   = ST_RESP;
        end else if (wd_expired) begin
          state_d = ST_FAULT;
        end
      end
      ST_RESP: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      mul_a_q   <= '0;
      mul_b_q   <= '0;
      out_res_q <= '0;
    end else begin
      state_q   <= state_d;
      mul_a_q   <= mul_a_d;
      mul_b_q   <= mul_b_d;
      out_res_q <= out_res_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign mul_start = (state_q == ST_START);
  assign out_valid = (state_q == ST_RESP);
  assign busy      = (state_q != ST_IDLE);
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign out_res   = out_res_q;

endmodule

// File: tb/tb_mult_host_seq.sv
// Scoreboard bench for mult_host_seq with a delay-programmable multiplier stub.
module tb_mult_host_seq;

  localparam int DW = 16;
  localparam int RW = 32;
  localparam int TO = 64;

  logic          clk, rst;
  logic          in_valid, in_ready;
  logic [DW-1:0] in_a, in_b;
  logic          mul_start, mul_done;
  logic [DW-1:0] mul_a, mul_b;
  logic [RW-1:0] mul_res;
  logic          out_valid, out_ready;
  logic [RW-1:0] out_res;
  logic          busy, err;

  mult_host_seq #(.DATA_W(DW), .RES_W(RW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_done(mul_done), .mul_res(mul_res),
    .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res),
    .busy(busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int starts = 0;
  int jobs   = 0;
  int txn    = 0;
  logic [RW-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Multiplier stub: latches operands at start, pulses done after stub_delay cycles.
  int          stub_delay = 10;
  bit          stub_never = 0;
  bit          spur_req   = 0;
  int          stub_cnt   = -1;
  logic [DW-1:0] sa, sb;

  always @(posedge clk) begin
    #1;
    mul_done = 1'b0;
    if (rst) begin
      stub_cnt = -1;
    end else if (spur_req) begin
      mul_done = 1'b1;
      mul_res  = 32'hDEAD_BEEF;
      spur_req = 0;
    end else if (mul_start) begin
      stub_cnt = stub_never ? -1 : stub_delay;
      sa = mul_a;
      sb = mul_b;
    end else if (stub_cnt > 0) begin
      stub_cnt--;
      if (stub_cnt == 0) begin
        mul_done = 1'b1;
        mul_res  = 32'(sa) * 32'(sb);
        stub_cnt = -1;
      end
    end
  end

  bit rand_ready = 0;
  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: protocol checks plus scoreboard pop on each accepted result.
  logic          prev_start = 0, prev_ov = 0, prev_done = 0;
  logic [DW-1:0] wait_a, wait_b;
  logic [RW-1:0] exp_r;

  always @(negedge clk) begin
    #2;
    if (!rst) begin
      if (mul_start) begin
        starts++;
        check("start_single", prev_start, 0);
        wait_a = mul_a;
        wait_b = mul_b;
      end else if (busy && !out_valid && !err) begin
        check("wait_a_stable", mul_a, wait_a);
        check("wait_b_stable", mul_b, wait_b);
      end
      if (out_valid && !prev_ov) check("done_to_valid", prev_done, 1);
      if (out_valid && out_ready) begin
        txn++;
        if (exp_q.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          exp_r = exp_q.pop_front();
          $display("txn %0d: out_res=%08h expected=%08h", txn, out_res, exp_r);
          check("result", out_res, exp_r);
        end
      end
    end
    prev_start = mul_start;
    prev_ov    = out_valid;
    prev_done  = mul_done;
  end

  task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b, input bit hold);
    bit ok = 0;
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    for (int t = 0; t < 300 && !ok; t++) begin
      if (in_ready) begin
        exp_q.push_back(32'(a) * 32'(b));
        jobs++;
        ok = 1;
      end
      @(negedge clk);
    end
    if (!hold) in_valid = 1'b0;
    check("accept_timeout", ok, 1);
  endtask

  task automatic wait_idle(input int limit);
    bit ok = 0;
    for (int t = 0; t < limit && !ok; t++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0) ok = 1;
    end
    check("idle_timeout", ok, 1);
  endtask

  task automatic wait_valid(input int limit);
    bit ok = 0;
    for (int t = 0; t < limit && !ok; t++) begin
      @(negedge clk);
      if (out_valid) ok = 1;
    end
    check("valid_timeout", ok, 1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_mul_start"}, mul_start, 0);
    check({tag, "_mul_a"}, mul_a, 0);
    check({tag, "_mul_b"}, mul_b, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_res"}, out_res, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_err"}, err, 0);
  endtask

  logic [RW-1:0] held;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0;
    out_ready = 1'b1; mul_done = 1'b0; mul_res = '0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_in_ready", in_ready, 1);

    // Basic job
    stub_delay = 10;
    send(16'h0003, 16'h0005, 0);
    wait_idle(100);
    check("basic_out_res", out_res, 32'h0000_000F);
    check("basic_starts", starts, 1);

    // Backpressure
    out_ready = 1'b0;
    stub_delay = 4;
    send(16'h1234, 16'h0010, 0);
    wait_valid(50);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_out_res", out_res, 32'h0001_2340);
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_idle_after_accept", in_ready, 1);

    // Back-to-back with in_valid held
    stub_delay = 3;
    send(16'h0001, 16'h0001, 1);
    send(16'hFFFF, 16'h0002, 1);
    send(16'h0000, 16'h0007, 0);
    wait_idle(100);
    check("b2b_last_res", out_res, 0);

    // Spurious done in IDLE
    held = out_res;
    spur_req = 1;
    repeat (2) @(negedge clk);
    check("spur_idle_busy", busy, 0);
    check("spur_idle_res", out_res, held);
    check("spur_idle_valid", out_valid, 0);

    // Spurious done in RESP
    out_ready = 1'b0;
    stub_delay = 2;
    send(16'h0009, 16'h0009, 0);
    wait_valid(50);
    spur_req = 1;
    repeat (2) @(negedge clk);
    check("spur_resp_valid", out_valid, 1);
    check("spur_resp_res", out_res, 32'd81);
    out_ready = 1'b1;
    wait_idle(50);

    // Reset mid-WAIT
    stub_delay = 20;
    send(16'h0005, 16'h0006, 0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals("midrst");
    exp_q.delete();
    rst = 1'b0;
    stub_delay = 5;
    send(16'h0007, 16'h0008, 0);
    wait_idle(100);
    check("after_rst_res", out_res, 32'd56);

    // Randomized jobs with random backpressure
    rand_ready = 1;
    for (int j = 0; j < 20; j++) begin
      stub_delay = $urandom_range(1, 12);
      send(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
    end
    in_valid = 1'b0;
    wait_idle(500);
    rand_ready = 0;
    @(negedge clk);
    out_ready = 1'b1;

`ifdef MULT_SEQ_WATCHDOG_EN
    begin
      int n = 0;
      bit hit = 0;
      stub_never = 1;
      send(16'h0002, 16'h0003, 0);
      for (int t = 0; t < 100 && !hit; t++) begin
        @(negedge clk);
        n++;
        if (err) hit = 1;
      end
      check("wd_fault_cycle", n, TO + 1);
      repeat (3) @(negedge clk);
      check("wd_err_sticky", err, 1);
      check("wd_in_ready", in_ready, 0);
      check("wd_busy", busy, 1);
      check("wd_out_valid", out_valid, 0);
      exp_q.delete();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("wd_err_cleared", err, 0);
      stub_never = 0;
      stub_delay = TO;
      send(16'h0004, 16'h0005, 0);
      wait_idle(200);
      check("wd_edge_res", out_res, 32'd20);
      check("wd_edge_err", err, 0);
    end
`else
    check("err_tied_low", err, 0);
`endif

    check("start_count", starts, jobs);
    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
